// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Pipeline boundary register with valid/ready handshake, flush,
//            optional 2-entry skid buffer and a saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 128,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_cnt;

    logic w_ready;
    logic w_valid;
    logic w_accept;
    logic w_emit;
    logic w_load_head_in;
    logic w_load_head_skid;
    logic w_load_skid;
    logic w_clr_head;

    assign w_valid  = (r_state != S_EMPTY);
    assign w_accept = i_valid & w_ready;
    assign w_emit   = w_valid & i_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            // Decoded straight from the state register, so no path from i_ready.
            assign w_ready = (r_state != S_TWO);
        end else begin : g_noskid
            assign w_ready = (r_state == S_EMPTY) | i_ready;
        end
    endgenerate

    always_comb begin
        w_next           = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clr_head       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next         = S_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_emit) begin
                    w_load_head_in = 1'b1;
                end else if (w_accept && (SKID_EN != 0)) begin
                    w_next      = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_emit) begin
                    w_next     = S_EMPTY;
                    w_clr_head = 1'b1;
                end
            end
            S_TWO: begin
                if (w_emit) begin
                    w_next           = S_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_next = S_EMPTY;
        endcase
        if (i_flush) begin
            w_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_head_ctrl <= '0;
            r_head_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_next;
            if (i_flush) begin
                // Data fields deliberately hold; only control is scrubbed.
                r_head_ctrl <= '0;
                r_skid_ctrl <= '0;
            end else begin
                if (w_load_head_in) begin
                    r_head_ctrl <= i_ctrl;
                    r_head_data <= i_data;
                end else if (w_load_head_skid) begin
                    r_head_ctrl <= r_skid_ctrl;
                    r_head_data <= r_skid_data;
                end else if (w_clr_head) begin
                    r_head_ctrl <= '0;
                end
                if (w_load_skid) begin
                    r_skid_ctrl <= i_ctrl;
                    r_skid_data <= i_data;
                end else if (w_load_head_skid) begin
                    r_skid_ctrl <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_ready && !w_valid && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_ready      = w_ready;
    assign o_valid      = w_valid;
    assign o_ctrl       = r_head_ctrl;
    assign o_data       = r_head_data;
    assign o_occupancy  = r_state;
    assign o_bubble_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg (skid and no-skid).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic clk;
    logic reset;

    logic        a_valid, a_ready, a_flush, a_ovalid, a_iready;
    logic [7:0]  a_ctrl, a_octrl;
    logic [31:0] a_data, a_odata;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;

    logic        b_valid, b_ready, b_flush, b_ovalid, b_iready;
    logic [7:0]  b_ctrl, b_octrl;
    logic [31:0] b_data, b_odata;
    logic [1:0]  b_occ;
    logic [3:0]  b_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID_EN(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_valid(a_valid), .o_ready(a_ready), .i_ctrl(a_ctrl), .i_data(a_data),
        .i_flush(a_flush), .o_valid(a_ovalid), .i_ready(a_iready),
        .o_ctrl(a_octrl), .o_data(a_odata), .o_occupancy(a_occ), .o_bubble_cnt(a_cnt)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID_EN(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_valid(b_valid), .o_ready(b_ready), .i_ctrl(b_ctrl), .i_data(b_data),
        .i_flush(b_flush), .o_valid(b_ovalid), .i_ready(b_iready),
        .o_ctrl(b_octrl), .o_data(b_odata), .o_occupancy(b_occ), .o_bubble_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [7:0] c,
                         input logic [31:0] d, input logic [1:0] occ, input logic rdy);
        chk({tag, ".valid"}, 64'(a_ovalid), 64'(v));
        chk({tag, ".ctrl"},  64'(a_octrl),  64'(c));
        chk({tag, ".data"},  64'(a_odata),  64'(d));
        chk({tag, ".occ"},   64'(a_occ),    64'(occ));
        chk({tag, ".ready"}, 64'(a_ready),  64'(rdy));
    endtask

    int b_ir [5] = '{1, 0, 1, 0, 1};
    int b_din[5] = '{32'h50, 32'h51, 32'h51, 32'h52, 32'h52};
    int b_rdy[5] = '{1, 0, 1, 0, 1};
    int b_exp[5] = '{32'h50, 32'h50, 32'h51, 32'h51, 32'h52};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        a_valid = 0; a_ctrl = 0; a_data = 0; a_flush = 0; a_iready = 0;
        b_valid = 0; b_ctrl = 0; b_data = 0; b_flush = 0; b_iready = 0;
        tick();
        tick();
        chk_a("rst_a", 0, 8'h00, 32'h0, 2'd0, 1);
        chk("rst_a.cnt", 64'(a_cnt), 64'd0);
        chk("rst_b.valid", 64'(b_ovalid), 64'd0);
        chk("rst_b.ready", 64'(b_ready), 64'd1);
        chk("rst_b.cnt", 64'(b_cnt), 64'd0);
        reset = 1'b0;

        // Streaming: first beat with downstream stalled, then full rate.
        a_valid = 1; a_data = 32'd100; a_ctrl = 8'h11; a_iready = 0;
        tick();
        chk_a("s1.b0", 1, 8'h11, 32'd100, 2'd1, 1);
        chk("s1.cnt0", 64'(a_cnt), 64'd0);
        a_iready = 1;
        for (int k = 1; k < 8; k++) begin
            a_data = 32'(100 + k);
            a_ctrl = 8'(8'h11 + k);
            tick();
            chk_a($sformatf("s1.b%0d", k), 1, 8'(8'h11 + k), 32'(100 + k), 2'd1, 1);
        end
        a_valid = 0; a_data = 32'hDEAD;
        tick();
        chk_a("s1.drain", 0, 8'h00, 32'd107, 2'd0, 1);
        chk("s1.cnt", 64'(a_cnt), 64'd0);
        a_iready = 0;

        // Skid fill and drain.
        a_valid = 1; a_data = 32'hA; a_ctrl = 8'h2A;
        tick();
        chk_a("s2.one", 1, 8'h2A, 32'hA, 2'd1, 1);
        a_data = 32'hB; a_ctrl = 8'h2B;
        tick();
        chk_a("s2.two", 1, 8'h2A, 32'hA, 2'd2, 0);
        a_data = 32'hFF; a_ctrl = 8'hFF;
        tick();
        chk_a("s2.hold", 1, 8'h2A, 32'hA, 2'd2, 0);
        a_valid = 0; a_iready = 1;
        tick();
        chk_a("s2.popA", 1, 8'h2B, 32'hB, 2'd1, 1);
        tick();
        chk_a("s2.popB", 0, 8'h00, 32'hB, 2'd0, 1);
        chk("s2.cnt", 64'(a_cnt), 64'd0);
        a_iready = 0;

        // Flush with both entries held and a beat offered.
        a_valid = 1; a_data = 32'hC; a_ctrl = 8'h3C;
        tick();
        a_data = 32'hD; a_ctrl = 8'h3D;
        tick();
        chk_a("s3.full", 1, 8'h3C, 32'hC, 2'd2, 0);
        a_flush = 1; a_data = 32'hE; a_ctrl = 8'h3E;
        tick();
        chk_a("s3.flush", 0, 8'h00, 32'hC, 2'd0, 1);
        a_flush = 0; a_valid = 0;
        tick();
        chk_a("s3.lost", 0, 8'h00, 32'hC, 2'd0, 1);
        a_iready = 1;
        tick();
        chk("s3.cnt", 64'(a_cnt), 64'd1);
        a_iready = 0;

        // Asynchronous reset in the middle of a cycle.
        a_valid = 1; a_data = 32'hF0; a_ctrl = 8'h4F;
        tick();
        a_data = 32'hF1; a_ctrl = 8'h41;
        tick();
        chk("s4.pre.occ", 64'(a_occ), 64'd2);
        a_valid = 0;
        #3 reset = 1'b1;
        #1;
        chk_a("s4.async", 0, 8'h00, 32'h0, 2'd0, 1);
        chk("s4.cnt", 64'(a_cnt), 64'd0);
        #2 reset = 1'b0;
        a_iready = 1;
        tick();
        chk_a("s4.after", 0, 8'h00, 32'h0, 2'd0, 1);
        chk("s4.cnt1", 64'(a_cnt), 64'd1);
        a_iready = 0;

        // Saturating 4-bit bubble counter on the no-skid instance.
        b_iready = 1; b_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("s5.cnt%0d", k), 64'(b_cnt), 64'((k > 15) ? 15 : k));
        end

        // No-skid instance with a toggling downstream.
        b_valid = 1;
        for (int k = 0; k < 5; k++) begin
            b_iready = b_ir[k][0];
            b_data   = 32'(b_din[k]);
            b_ctrl   = 8'(b_din[k] + 16);
            #1;
            chk($sformatf("s6.rdy%0d", k), 64'(b_ready), 64'(b_rdy[k]));
            tick();
            chk($sformatf("s6.dat%0d", k), 64'(b_odata), 64'(b_exp[k]));
            chk($sformatf("s6.ctl%0d", k), 64'(b_octrl), 64'(b_exp[k] + 16));
            chk($sformatf("s6.occ%0d", k), 64'(b_occ), 64'd1);
        end
        b_valid = 0; b_iready = 1;
        tick();
        chk("s6.end.valid", 64'(b_ovalid), 64'd0);
        chk("s6.end.ctrl", 64'(b_octrl), 64'd0);
        chk("s6.end.occ", 64'(b_occ), 64'd0);
        chk("s6.end.cnt", 64'(b_cnt), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
